// File: rtl/bp_cfg_link_loader.sv
// bp_cfg_link_loader: boot sequencer for the tile config link. It freezes the core,
//   writes the identity and cache mode registers, and streams CCE microcode from a sync ROM.
//   It then writes the boot PC and unfreezes the core.
// Latency: one cfg write per handshake for register writes; microcode takes at least 2 cycles
//   per word (ROM read, then write).
// Backpressure: a command, once valid, is held unchanged until it is accepted by cfg_ready_i.
//   A new command is only issued while fewer than max_credits_p writes are still unacked.
// Ports: clk_i/reset_i (sync, active-high); start_i kicks off the sequence from IDLE;
//   cfg_v_o/cfg_ready_i/cfg_addr_o/cfg_data_o form the write command; cfg_ack_i pulses once per
//   completed write; ucode_addr_o/ucode_data_i are the microcode ROM port;
//   busy_o/done_o report status (done_o is sticky until reset).
module bp_cfg_link_loader #(
  parameter int ucode_words_p    = 256,
  parameter int cfg_data_width_p = 64,
  parameter int max_credits_p    = 4,
  parameter logic [cfg_data_width_p-1:0] core_id_p     = '0,
  parameter logic [cfg_data_width_p-1:0] did_p         = '0,
  parameter logic [cfg_data_width_p-1:0] cord_p        = '0,
  parameter logic [cfg_data_width_p-1:0] icache_mode_p = 1,
  parameter logic [cfg_data_width_p-1:0] dcache_mode_p = 1,
  parameter logic [cfg_data_width_p-1:0] npc_p         = 'h8000_0000,
  localparam int uc_addr_w_lp = (ucode_words_p > 1) ? $clog2(ucode_words_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [15:0]                 cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_i,
  output logic [uc_addr_w_lp-1:0]     ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int cred_w_lp = $clog2(max_credits_p + 1);

  typedef enum logic [3:0] {
    IDLE, FREEZE, CORE_ID, DID, CORD, ICMODE, DCMODE, CCE_UC,
    UC_RD, UC_WR, NPC, CCE_NORM, UNFREEZE, DRAIN, DONE
  } state_e;

  state_e                        state_r, state_n, adv_state;
  logic [uc_addr_w_lp-1:0]       idx_r;
  logic [cred_w_lp-1:0]          credits_r;
  logic [cfg_data_width_p-1:0]   uc_data_r;
  logic                          issue;
  logic                          uc_last;
  logic                          hs;

  assign uc_last = (idx_r == uc_addr_w_lp'(ucode_words_p - 1));
  assign hs      = cfg_v_o & cfg_ready_i;
  assign done_o  = (state_r == DONE);
  assign busy_o  = (state_r != IDLE) && (state_r != DONE);

  // Next-state and command decode. Each write state names the state that follows
  // its handshake in adv_state; the handshake itself is resolved after the case.
  always_comb begin
    state_n    = state_r;
    adv_state  = state_r;
    issue      = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    unique case (state_r)
      IDLE:     if (start_i) state_n = FREEZE;
      FREEZE:   begin issue = 1'b1; cfg_addr_o = 16'h0002; cfg_data_o = cfg_data_width_p'(1); adv_state = CORE_ID; end
      CORE_ID:  begin issue = 1'b1; cfg_addr_o = 16'h0005; cfg_data_o = core_id_p;     adv_state = DID;      end
      DID:      begin issue = 1'b1; cfg_addr_o = 16'h0006; cfg_data_o = did_p;         adv_state = CORD;     end
      CORD:     begin issue = 1'b1; cfg_addr_o = 16'h0007; cfg_data_o = cord_p;        adv_state = ICMODE;   end
      ICMODE:   begin issue = 1'b1; cfg_addr_o = 16'h0022; cfg_data_o = icache_mode_p; adv_state = DCMODE;   end
      DCMODE:   begin issue = 1'b1; cfg_addr_o = 16'h0043; cfg_data_o = dcache_mode_p; adv_state = CCE_UC;   end
      CCE_UC:   begin issue = 1'b1; cfg_addr_o = 16'h0081; cfg_data_o = '0;            adv_state = UC_RD;    end
      UC_RD:    state_n = UC_WR;
      UC_WR:    begin
                  issue      = 1'b1;
                  cfg_addr_o = 16'h8000 | 16'(idx_r);
                  cfg_data_o = uc_data_r;
                  adv_state  = uc_last ? NPC : UC_RD;
                end
      NPC:      begin issue = 1'b1; cfg_addr_o = 16'h0040; cfg_data_o = npc_p;         adv_state = CCE_NORM; end
      CCE_NORM: begin issue = 1'b1; cfg_addr_o = 16'h0081; cfg_data_o = cfg_data_width_p'(1); adv_state = UNFREEZE; end
      UNFREEZE: begin issue = 1'b1; cfg_addr_o = 16'h0002; cfg_data_o = '0;            adv_state = DRAIN;    end
      DRAIN:    if (credits_r == '0) state_n = DONE;
      DONE:     state_n = DONE;
      default:  state_n = IDLE;
    endcase
    // Credits can only rise on a handshake, so a raised valid never drops before acceptance.
    cfg_v_o = issue && (credits_r < cred_w_lp'(max_credits_p));
    if (cfg_v_o && cfg_ready_i) state_n = adv_state;
  end

  // The ROM port looks one word ahead while a ucode write is pending, so the sync
  // ROM output is already valid for the next index by the time UC_RD is entered.
  always_comb begin
    ucode_addr_o = idx_r;
    if (state_r == UC_WR && !uc_last) ucode_addr_o = idx_r + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      credits_r <= '0;
      uc_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == UC_RD) uc_data_r <= ucode_data_i;
      if (state_r == UC_WR && hs && !uc_last) idx_r <= idx_r + 1'b1;
      // Simultaneous handshake and ack cancel out; a stray ack saturates at zero.
      if (hs && !cfg_ack_i)
        credits_r <= credits_r + 1'b1;
      else if (!hs && cfg_ack_i && credits_r != '0)
        credits_r <= credits_r - 1'b1;
    end
  end

  ack_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(cfg_ack_i && credits_r == '0));

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
module tb_bp_cfg_link_loader;

  localparam int mc_lp = 4;

  logic        clk = 1'b0;
  logic        reset_i, start_i, cfg_v_o, cfg_ready_i, cfg_ack_i, busy_o, done_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o, ucode_data_i;
  logic [1:0]  ucode_addr_o;

  always #5 clk = ~clk;

  bp_cfg_link_loader #(
    .ucode_words_p(4), .cfg_data_width_p(64), .max_credits_p(mc_lp),
    .core_id_p(64'd3), .did_p(64'd5), .cord_p(64'd7),
    .icache_mode_p(64'd1), .dcache_mode_p(64'd1), .npc_p(64'h8000_0000)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .cfg_ack_i(cfg_ack_i),
    .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_ack = 1'b1;
  bit rand_ready = 1'b0;
  int owed = 0;
  int hs_count = 0;
  int ack_count = 0;
  logic [15:0] got_addr[$];
  logic [63:0] got_data[$];
  logic [15:0] exp_addr[$];
  logic [63:0] exp_data[$];

  // Reference write list: register table plus ROM[i] = i + 'hA0 streamed to 'h8000 + i.
  task automatic add_exp(input logic [15:0] a, input logic [63:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic build_expected();
    add_exp(16'h0002, 64'd1); add_exp(16'h0005, 64'd3); add_exp(16'h0006, 64'd5);
    add_exp(16'h0007, 64'd7); add_exp(16'h0022, 64'd1); add_exp(16'h0043, 64'd1);
    add_exp(16'h0081, 64'd0);
    for (int i = 0; i < 4; i++) add_exp(16'h8000 + 16'(i), 64'hA0 + 64'(i));
    add_exp(16'h0040, 64'h8000_0000); add_exp(16'h0081, 64'd1); add_exp(16'h0002, 64'd0);
  endtask

  // Index of the first observed write that differs from the reference list, -1 if identical.
  function automatic int first_bad();
    int n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) return i;
    if (got_addr.size() != exp_addr.size()) return n;
    return -1;
  endfunction

  // Responder: samples the command at the falling edge, resolves the handshake after the
  // rising edge, returns acks, serves the sync ROM and drives ready.
  initial begin : responder
    logic s_v, s_rdy, stall;
    logic [15:0] s_a, stall_a;
    logic [63:0] s_d, stall_d;
    logic [1:0]  s_ua;
    stall = 1'b0; stall_a = '0; stall_d = '0;
    forever begin
      @(negedge clk);
      s_v = cfg_v_o; s_rdy = cfg_ready_i; s_a = cfg_addr_o; s_d = cfg_data_o; s_ua = ucode_addr_o;
      if (stall) begin
        n_checks++;
        if (s_v !== 1'b1 || s_a !== stall_a || s_d !== stall_d)
          $display("FAIL hold_stable: v=%b addr=%h data=%h, required v=1 addr=%h data=%h",
                   s_v, s_a, s_d, stall_a, stall_d);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (reset_i) begin
        owed = 0; stall = 1'b0; cfg_ack_i = 1'b0;
      end else begin
        if (s_v && s_rdy) begin
          got_addr.push_back(s_a); got_data.push_back(s_d);
          hs_count++;
          if (auto_ack) owed++;
        end
        stall = s_v && !s_rdy; stall_a = s_a; stall_d = s_d;
        if (owed > 0) begin cfg_ack_i = 1'b1; owed--; ack_count++; end
        else cfg_ack_i = 1'b0;
      end
      ucode_data_i = 64'(s_ua) + 64'hA0;
      cfg_ready_i  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at a falling edge; holds reset across one rising edge and optionally checks outputs.
  task automatic do_reset(input bit chk, input string tag);
    #1 reset_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #2;
    if (chk) begin
      n_checks++;
      if (cfg_v_o !== 1'b0) $display("FAIL %s_v: cfg_v_o=%b, required 0", tag, cfg_v_o); else n_pass++;
      n_checks++;
      if (cfg_addr_o !== 16'h0) $display("FAIL %s_addr: cfg_addr_o=%h, required 0", tag, cfg_addr_o); else n_pass++;
      n_checks++;
      if (cfg_data_o !== 64'h0) $display("FAIL %s_data: cfg_data_o=%h, required 0", tag, cfg_data_o); else n_pass++;
      n_checks++;
      if (ucode_addr_o !== 2'h0) $display("FAIL %s_uaddr: ucode_addr_o=%h, required 0", tag, ucode_addr_o); else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL %s_busy: busy_o=%b, required 0", tag, busy_o); else n_pass++;
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL %s_done: done_o=%b, required 0", tag, done_o); else n_pass++;
    end
    reset_i = 1'b0;
    hs_count = 0; ack_count = 0; owed = 0;
    got_addr.delete(); got_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(1'b1, "reset");
    repeat (5) @(negedge clk);
    n_checks++;
    if (cfg_v_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL idle_no_start: v=%b busy=%b, required 0 0", cfg_v_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_basic();
    int b;
    @(negedge clk); do_reset(1'b0, "");
    auto_ack = 1'b1; rand_ready = 1'b0;
    pulse_start();
    n_checks++;
    if (busy_o !== 1'b1 || cfg_v_o !== 1'b1)
      $display("FAIL basic_first: busy=%b v=%b, required 1 1", busy_o, cfg_v_o);
    else n_pass++;
    wait_done(300);
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL basic_done: done=%b busy=%b, required 1 0", done_o, busy_o);
    else n_pass++;
    n_checks++;
    if (ack_count !== 14) $display("FAIL basic_acks: %0d acks at done, required 14", ack_count); else n_pass++;
    b = first_bad();
    n_checks++;
    if (b !== -1) $display("FAIL basic_order: first bad write %0d of %0d, required 14 in order", b, got_addr.size());
    else n_pass++;
  endtask

  task automatic test_ready_random();
    int b;
    @(negedge clk); do_reset(1'b0, "");
    auto_ack = 1'b1; rand_ready = 1'b1;
    pulse_start();
    wait_done(1000);
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL rand_done: done=%b, required 1", done_o); else n_pass++;
    b = first_bad();
    n_checks++;
    if (b !== -1) $display("FAIL rand_order: first bad write %0d of %0d, required 14 in order", b, got_addr.size());
    else n_pass++;
    rand_ready = 1'b0;
  endtask

  task automatic test_credits();
    int acks_given, exp_hs, b;
    int step_acks[3] = '{0, 1, 2};
    @(negedge clk); do_reset(1'b0, "");
    auto_ack = 1'b0; rand_ready = 1'b0; acks_given = 0;
    pulse_start();
    // Second step overlaps an ack with the handshake that follows it.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      owed += step_acks[s]; acks_given += step_acks[s];
      repeat (20) @(negedge clk);
      exp_hs = (acks_given + mc_lp < 14) ? acks_given + mc_lp : 14;
      n_checks++;
      if (hs_count !== exp_hs || cfg_v_o !== 1'b0)
        $display("FAIL credits_step%0d: handshakes=%0d v=%b, required %0d 0", s, hs_count, cfg_v_o, exp_hs);
      else n_pass++;
    end
    auto_ack = 1'b1;
    owed += hs_count - ack_count;
    wait_done(400);
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL credits_done: done=%b, required 1", done_o); else n_pass++;
    b = first_bad();
    n_checks++;
    if (b !== -1) $display("FAIL credits_order: first bad write %0d of %0d, required 14 in order", b, got_addr.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, b;
    @(negedge clk); do_reset(1'b0, "");
    auto_ack = 1'b1; rand_ready = 1'b0;
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!(cfg_v_o === 1'b1 && cfg_addr_o === 16'h8002) && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (cfg_addr_o !== 16'h8002 || hs_count !== 9)
      $display("FAIL midrst_reach: addr=%h handshakes=%0d, required 8002 9", cfg_addr_o, hs_count);
    else n_pass++;
    do_reset(1'b1, "midrst");
    repeat (10) @(negedge clk);
    n_checks++;
    if (cfg_v_o !== 1'b0 || busy_o !== 1'b0 || hs_count !== 0)
      $display("FAIL midrst_idle: v=%b busy=%b handshakes=%0d, required 0 0 0", cfg_v_o, busy_o, hs_count);
    else n_pass++;
    pulse_start();
    wait_done(300);
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL midrst_done: done=%b, required 1", done_o); else n_pass++;
    b = first_bad();
    n_checks++;
    if (b !== -1) $display("FAIL midrst_order: first bad write %0d of %0d, required 14 in order", b, got_addr.size());
    else n_pass++;
  endtask

  task automatic test_start_after_done();
    @(negedge clk); #1 start_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (cfg_v_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0)
        $display("FAIL after_done_c%0d: v=%b done=%b busy=%b, required 0 1 0", c, cfg_v_o, done_o, busy_o);
      else n_pass++;
    end
    start_i = 1'b0;
    n_checks++;
    if (hs_count !== 14) $display("FAIL after_done_hs: handshakes=%0d, required 14", hs_count); else n_pass++;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; cfg_ready_i = 1'b1; cfg_ack_i = 1'b0; ucode_data_i = '0;
    build_expected();
    test_reset();
    test_basic();
    test_ready_random();
    test_credits();
    test_reset_mid();
    test_start_after_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
